// File: rtl/riscv_pkg.sv
// Shared constants and the instruction-fetch response record.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR          = 32'h0000_0013;
  localparam int          IMEM_WORDS_DEFAULT = 1024;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] addr;
    logic        err;
  } imem_resp_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO of arbitrary depth (not restricted to powers of two) with
// a synchronous clear. Pointers wrap modulo DEPTH; pushes while full without a
// simultaneous pop and pops while empty are ignored.
module sync_fifo #(
  parameter int  DEPTH = 3,
  parameter type T     = logic [7:0]
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         push,
  input  T                             din,
  input  logic                         pop,
  output T                             dout,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int              PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CW     = $clog2(DEPTH + 1);
  localparam logic [PW-1:0]   LAST   = PW'(DEPTH - 1);
  localparam logic [CW-1:0]   FULL_C = CW'(DEPTH);

  T              mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == FULL_C);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];

  // Pointer and occupancy bookkeeping; clear behaves exactly like reset.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wrap_inc(wptr);
      if (do_pop)  rptr <= wrap_inc(rptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries data only, so it is never reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction memory responder: accepts byte-addressed fetch requests, reads
// the word in a single read stage and queues responses in order. A flush
// (branch redirect) or reset drops everything in flight. The array is loaded
// through a backdoor write port and is never cleared.
module imem_responder
  import riscv_pkg::*;
#(
  parameter int MEM_WORDS  = IMEM_WORDS_DEFAULT,
  parameter int FIFO_DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [63:0] req_addr_i,
  input  logic        flush_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_instr_o,
  output logic [63:0] resp_addr_o,
  output logic        resp_err_o,
  input  logic        load_we_i,
  input  logic [63:0] load_addr_i,
  input  logic [31:0] load_data_i
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0] mem [MEM_WORDS];

  logic [61:0] req_idx;
  logic [61:0] load_idx;
  logic        req_err;
  logic        accept;
  logic [CW:0] occupancy;

  logic        vld_p1;
  logic [63:0] addr_p1;
  logic        err_p1;
  logic [31:0] instr_p1;

  imem_resp_t  push_data;
  imem_resp_t  head;
  logic        fifo_empty;
  logic [CW-1:0] fifo_count;

  function automatic logic in_range(input logic [61:0] idx);
    return idx < 62'(MEM_WORDS);
  endfunction

  assign req_idx  = req_addr_i[63:2];
  assign load_idx = load_addr_i[63:2];
  assign req_err  = (req_addr_i[1:0] != 2'b00) || !in_range(req_idx);

  // Count the read-stage slot as occupied so that every accepted request is
  // guaranteed a FIFO entry; ready therefore never looks at resp_ready_i.
  assign occupancy   = {1'b0, fifo_count} + {{CW{1'b0}}, vld_p1};
  assign req_ready_o = !flush_i && (occupancy < (CW + 1)'(FIFO_DEPTH));
  assign accept      = req_valid_i && req_ready_o;

  // ---- stage p0 -> p1: accept request, read array ----

  // Read-stage valid; dropped by reset and by flush.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) vld_p1 <= 1'b0;
    else                   vld_p1 <= accept;
  end

  // Read-stage payload; erroneous requests bypass the array and return a NOP.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p1 <= req_addr_i;
      err_p1  <= req_err;
      if (req_err) instr_p1 <= NOP_INSTR;
      else         instr_p1 <= mem[req_idx[AW-1:0]];
    end
  end

  // Backdoor program load; out-of-range writes are dropped. A read of the
  // same word in the same cycle sees the old contents.
  always_ff @(posedge clk) begin
    if (load_we_i && in_range(load_idx)) mem[load_idx[AW-1:0]] <= load_data_i;
  end

  // ---- stage p1 -> response queue ----

  assign push_data = '{instr: instr_p1, addr: addr_p1, err: err_p1};

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (imem_resp_t)
  ) u_resp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush_i),
    .push  (vld_p1),
    .din   (push_data),
    .pop   (resp_valid_o && resp_ready_i),
    .dout  (head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Outputs read as zero whenever the queue is empty, including after reset.
  assign resp_valid_o = !fifo_empty;
  assign resp_instr_o = resp_valid_o ? head.instr : '0;
  assign resp_addr_o  = resp_valid_o ? head.addr  : '0;
  assign resp_err_o   = resp_valid_o && head.err;

endmodule
